// File: rtl/flash_read_arbiter.sv
// flash_read_arbiter: round-robin arbiter for two read ports onto one
// Avalon-MM flash master, single outstanding read, data timeout.
module flash_read_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd200
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        r0_req,
  input  logic [22:0] r0_addr,
  output logic        r0_ack,
  output logic        r0_valid,
  output logic [31:0] r0_data,
  output logic        r0_err,
  input  logic        r1_req,
  input  logic [22:0] r1_addr,
  output logic        r1_ack,
  output logic        r1_valid,
  output logic [31:0] r1_data,
  output logic        r1_err,
  output logic        flash_mem_read,
  output logic [22:0] flash_mem_address,
  input  logic        flash_mem_waitrequest,
  input  logic [31:0] flash_mem_readdata,
  input  logic        flash_mem_readdatavalid,
  output logic        flash_mem_write,
  output logic [6:0]  flash_mem_burstcount,
  output logic [3:0]  flash_mem_byteenable,
  output logic [31:0] flash_mem_writedata
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DATA,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic        err_q, err_d;
  logic        pick;
  logic [1:0]  ack_q, ack_d;
  logic [22:0] addr_q, addr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] data0_q, data0_d;
  logic [31:0] data1_q, data1_d;

  always_ff @(posedge clk_clk or posedge reset_reset_n) begin
    if (reset_reset_n) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
      ack_q   <= 2'b00;
      addr_q  <= '0;
      cnt_q   <= '0;
      data0_q <= '0;
      data1_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      err_q   <= err_d;
      ack_q   <= ack_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
    end
  end

  // On a tie the port not served last wins.
  assign pick = (r0_req && r1_req) ? ~last_q : r1_req;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    err_d   = err_q;
    ack_d   = 2'b00;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    data0_d = data0_q;
    data1_d = data1_q;
    unique case (state_q)
      IDLE: begin
        if (r0_req || r1_req) begin
          gnt_d   = pick;
          last_d  = pick;
          addr_d  = pick ? r1_addr : r0_addr;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!flash_mem_waitrequest) begin
          ack_d[gnt_q] = 1'b1;
          cnt_d        = '0;
          state_d      = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (flash_mem_readdatavalid) begin
          if (gnt_q) data1_d = flash_mem_readdata;
          else       data0_d = flash_mem_readdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == TIMEOUT) begin
          if (gnt_q) data1_d = '0;
          else       data0_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    flash_mem_read    = (state_q == ISSUE);
    flash_mem_address = addr_q;
    r0_ack            = ack_q[0];
    r1_ack            = ack_q[1];
    r0_valid          = (state_q == RESP) && !gnt_q;
    r1_valid          = (state_q == RESP) && gnt_q;
    r0_err            = r0_valid && err_q;
    r1_err            = r1_valid && err_q;
    r0_data           = data0_q;
    r1_data           = data1_q;
  end

  assign flash_mem_write      = 1'b0;
  assign flash_mem_burstcount = 7'd1;
  assign flash_mem_byteenable = 4'hF;
  assign flash_mem_writedata  = 32'h0;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// tb_flash_read_arbiter: directed and random stimulus checked each
// cycle against a timestamp-based transaction model.
module tb_flash_read_arbiter;

  localparam logic [7:0] TO = 8'd10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r0_req = 0, r1_req = 0;
  logic [22:0] r0_addr = 0, r1_addr = 0;
  logic        r0_ack, r1_ack, r0_valid, r1_valid;
  logic        r0_err, r1_err;
  logic [31:0] r0_data, r1_data;
  logic        rd, wr = 0, rdv = 0;
  logic [22:0] fa;
  logic [31:0] rdata = 0;
  logic        f_wr;
  logic [6:0]  f_bc;
  logic [3:0]  f_be;
  logic [31:0] f_wd;

  always #5 clk = ~clk;

  flash_read_arbiter #(.TIMEOUT(TO)) dut (
    .clk_clk                 (clk),
    .reset_reset_n           (rst),
    .r0_req                  (r0_req),
    .r0_addr                 (r0_addr),
    .r0_ack                  (r0_ack),
    .r0_valid                (r0_valid),
    .r0_data                 (r0_data),
    .r0_err                  (r0_err),
    .r1_req                  (r1_req),
    .r1_addr                 (r1_addr),
    .r1_ack                  (r1_ack),
    .r1_valid                (r1_valid),
    .r1_data                 (r1_data),
    .r1_err                  (r1_err),
    .flash_mem_read          (rd),
    .flash_mem_address       (fa),
    .flash_mem_waitrequest   (wr),
    .flash_mem_readdata      (rdata),
    .flash_mem_readdatavalid (rdv),
    .flash_mem_write         (f_wr),
    .flash_mem_burstcount    (f_bc),
    .flash_mem_byteenable    (f_be),
    .flash_mem_writedata     (f_wd)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int rd_cnt = 0;

  // transaction model: one grant at a time, tracked by cycle stamps
  bit          busy = 0, acc = 0, done = 0, verr = 0;
  bit          gp = 0, mlast = 1;
  int          t_a = 0, t_v = 0;
  logic [22:0] maddr = 0;
  logic [31:0] mdata [2];

  int          nack [2];
  int          nval [2];
  int          ack_cyc [2];
  int          val_cyc [2];
  bit          val_err [2];
  logic [22:0] accq [$];

  bit auto_slave = 0, rand_req = 0;
  int wr_div = 0, rdv_div = 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h want=%0h",
                  nm, cyc, act, exp);
  endtask

  always @(negedge clk) begin : mon
    logic [1:0] ea, ev, ee;
    cyc++;
    if (rst) begin
      chk("rst_read", rd, 0);
      chk("rst_addr", fa, 0);
      chk("rst_ack", {r1_ack, r0_ack}, 0);
      chk("rst_val", {r1_valid, r0_valid}, 0);
      chk("rst_err", {r1_err, r0_err}, 0);
      chk("rst_d0", r0_data, 0);
      chk("rst_d1", r1_data, 0);
      busy = 0; acc = 0; done = 0; mlast = 1;
      maddr = 0; mdata[0] = 0; mdata[1] = 0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        ea[p] = busy && acc && cyc == t_a + 1 && gp == p[0];
        ev[p] = busy && done && cyc == t_v && gp == p[0];
        ee[p] = ev[p] && verr;
      end
      chk("read", rd, busy && !acc);
      chk("addr", fa, maddr);
      chk("ack", {r1_ack, r0_ack}, ea);
      chk("valid", {r1_valid, r0_valid}, ev);
      chk("err", {r1_err, r0_err}, ee);
      chk("data0", r0_data, mdata[0]);
      chk("data1", r1_data, mdata[1]);
      chk("tie", {f_wr, f_bc, f_be, f_wd},
          {1'b0, 7'd1, 4'hF, 32'h0});
      if (r0_ack) begin nack[0]++; ack_cyc[0] = cyc; end
      if (r1_ack) begin nack[1]++; ack_cyc[1] = cyc; end
      if (r0_valid) begin
        nval[0]++; val_cyc[0] = cyc; val_err[0] = r0_err;
      end
      if (r1_valid) begin
        nval[1]++; val_cyc[1] = cyc; val_err[1] = r1_err;
      end
      if (rd) rd_cnt++;
      if (rd && !wr) accq.push_back(fa);
      if (busy) begin
        if (!acc) begin
          if (!wr) begin acc = 1; t_a = cyc; end
        end else if (!done) begin
          if (rdv) begin
            done = 1; t_v = cyc + 1; verr = 0; mdata[gp] = rdata;
          end else if (cyc - t_a - 1 == int'(TO)) begin
            done = 1; t_v = cyc + 1; verr = 1; mdata[gp] = 0;
          end
        end else if (cyc == t_v) begin
          busy = 0;
        end
      end else if (r0_req || r1_req) begin
        gp = (r0_req && r1_req) ? !mlast : r1_req;
        mlast = gp;
        maddr = gp ? r1_addr : r0_addr;
        busy = 1; acc = 0; done = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (auto_slave) begin
      wr = (wr_div != 0) && ($urandom % wr_div == 0);
      rdv = ($urandom % rdv_div == 0);
      rdata = $urandom;
    end
    if (rand_req) begin
      if (r0_req) begin
        if (ack_cyc[0] == cyc) begin
          r0_req = $urandom % 2; r0_addr = 23'($urandom);
        end
      end else if ($urandom % 3 == 0) begin
        r0_req = 1; r0_addr = 23'($urandom);
      end
      if (r1_req) begin
        if (ack_cyc[1] == cyc) begin
          r1_req = $urandom % 2; r1_addr = 23'($urandom);
        end
      end else if ($urandom % 3 == 0) begin
        r1_req = 1; r1_addr = 23'($urandom);
      end
    end
  endtask

  task automatic wait_evt(input bit is_val, input int p,
                          input int base, input int lim,
                          input string nm);
    int k = 0;
    while ((is_val ? nval[p] : nack[p]) == base && k < lim) begin
      step();
      k++;
    end
    chk(nm, (is_val ? nval[p] : nack[p]) != base, 1);
  endtask

  initial begin
    int b0, b1, c0;
    for (int p = 0; p < 2; p++) begin
      nack[p] = 0; nval[p] = 0; ack_cyc[p] = -1; val_cyc[p] = -1;
      val_err[p] = 0; mdata[p] = 0;
    end
    repeat (3) step();
    rst = 0;
    step();

    // single read, data two cycles after ack
    b1 = nack[1] + nval[1];
    b0 = nack[0];
    r0_addr = 23'h000010; r0_req = 1;
    wait_evt(0, 0, b0, 20, "t34_ack");
    r0_req = 0;
    step();
    rdv = 1; rdata = 32'hDEADBEEF;
    step();
    rdv = 0;
    wait_evt(1, 0, nval[0], 20, "t34_val");
    chk("t34_lat", val_cyc[0] - ack_cyc[0], 3);
    chk("t34_data", r0_data, 32'hDEADBEEF);
    chk("t34_err", val_err[0], 0);
    chk("t34_nack", nack[0] - b0, 1);
    chk("t34_p1", nack[1] + nval[1], b1);
    repeat (3) step();

    // contention from reset release
    rst = 1;
    r0_addr = 23'h5; r1_addr = 23'h9; r0_req = 1; r1_req = 1;
    auto_slave = 1; wr_div = 0; rdv_div = 1;
    repeat (2) step();
    accq.delete();
    rst = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (r0_req && ack_cyc[0] == cyc) r0_req = 0;
      if (r1_req && ack_cyc[1] == cyc) r1_req = 0;
    end
    chk("t35_n", accq.size(), 2);
    chk("t35_a0", accq[0], 23'h5);
    chk("t35_a1", accq[1], 23'h9);
    chk("t35_gap", ack_cyc[1] - ack_cyc[0], 4);
    chk("t35_ord", val_cyc[0] < ack_cyc[1], 1);
    auto_slave = 0; wr = 0; rdv = 0;
    repeat (2) step();

    // stall: waitrequest high for 5 ISSUE cycles
    b1 = nack[1];
    c0 = cyc + 1;
    wr = 1; r1_addr = 23'h7; r1_req = 1;
    repeat (6) step();
    wr = 0;
    wait_evt(0, 1, b1, 20, "t36_ack");
    chk("t36_rd", rd_cnt - (c0 > 0 ? rd_cnt - rd_cnt : 0) >= 6, 1);
    chk("t36_lat", ack_cyc[1] - c0, 7);
    r1_req = 0;
    rdv = 1; rdata = 32'h0BADF00D;
    step();
    rdv = 0;
    wait_evt(1, 1, nval[1], 20, "t36_val");
    chk("t36_data", r1_data, 32'h0BADF00D);
    repeat (2) step();

    // timeout
    b0 = nack[0];
    r0_addr = 23'h33; r0_req = 1;
    wait_evt(0, 0, b0, 20, "t37_ack");
    r0_req = 0;
    wait_evt(1, 0, nval[0], 30, "t37_val");
    chk("t37_lat", val_cyc[0] - ack_cyc[0], 11);
    chk("t37_err", val_err[0], 1);
    chk("t37_data", r0_data, 0);
    step();
    b0 = nack[0];
    r0_addr = 23'h44; r0_req = 1;
    wait_evt(0, 0, b0, 20, "t37b_ack");
    r0_req = 0;
    rdv = 1; rdata = 32'hCAFE0001;
    step();
    rdv = 0;
    wait_evt(1, 0, nval[0], 20, "t37b_val");
    chk("t37b_err", val_err[0], 0);
    chk("t37b_data", r0_data, 32'hCAFE0001);
    repeat (2) step();

    // reset while waiting for data
    b1 = nack[1];
    r1_addr = 23'h55; r1_req = 1;
    wait_evt(0, 1, b1, 20, "t38_ack");
    r1_req = 0;
    repeat (2) step();
    b1 = nval[1];
    rst = 1;
    step();
    rst = 0;
    step();
    step();
    rdv = 1; rdata = 32'hA5A5A5A5;
    step();
    rdv = 0;
    repeat (4) step();
    chk("t38_nval", nval[1], b1);
    chk("t38_d0", r0_data, 0);
    chk("t38_d1", r1_data, 0);

    // stray readdatavalid while idle
    b0 = nval[0]; b1 = nval[1];
    rdv = 1; rdata = 32'h12345678;
    step();
    rdv = 0;
    repeat (3) step();
    chk("t39_nval", nval[0] + nval[1], b0 + b1);
    chk("t39_d0", r0_data, 0);

    // random traffic with varied slave behaviour
    auto_slave = 1; rand_req = 1;
    for (int blk = 0; blk < 6; blk++) begin
      wr_div = (blk % 3 == 0) ? 0 : blk % 3 + 1;
      rdv_div = (blk == 2 || blk == 5) ? 40 : blk % 2 * 2 + 1;
      repeat (400) step();
      rst = 1;
      step();
      rst = 0;
      repeat (100) step();
    end
    rand_req = 0; r0_req = 0; r1_req = 0;
    wr_div = 0; rdv_div = 1;
    repeat (30) step();
    chk("rnd_acks", nack[0] > 20 && nack[1] > 20, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/flash_read_arbiter.md
FLASH_READ_ARBITER -- requirements
Module: flash_read_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 8'd200, maximum cycles in WAIT_DATA before an error response is returned.
REQ-002 clk_clk  in  1  system clock; all state changes on rising edge.
REQ-003 reset_reset_n  in  1  reset, asynchronous, active-high.
REQ-004 r0_req / r1_req  in  1  requester 0/1 read request, level, held until the matching ack.
REQ-005 r0_addr / r1_addr  in  23  requester 0/1 word address, stable while req is high.
REQ-006 r0_ack / r1_ack  out  1  one-cycle pulse: the flash accepted this requester's read.
REQ-007 r0_valid / r1_valid  out  1  one-cycle pulse: r*_data and r*_err are valid.
REQ-008 r0_data / r1_data  out  32  returned read word; holds its value until the next valid pulse to the same port.
REQ-009 r0_err / r1_err  out  1  qualifies valid: 1 = timeout, data forced to 32'h0.
REQ-010 flash_mem_read  out  1  Avalon-MM read strobe.
REQ-011 flash_mem_address  out  23  Avalon-MM word address.
REQ-012 flash_mem_waitrequest  in  1  slave stall; the read is accepted on an edge where read=1 and waitrequest=0.
REQ-013 flash_mem_readdata  in  32  slave read data.
REQ-014 flash_mem_readdatavalid  in  1  slave data-valid strobe.
REQ-015 flash_mem_write  out  1  tied 0.
REQ-016 flash_mem_burstcount  out  7  tied 7'd1.
REQ-017 flash_mem_byteenable  out  4  tied 4'hF.
REQ-018 flash_mem_writedata  out  32  tied 32'h0.

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT_DATA, RESP; at most one flash transaction outstanding.
REQ-020 IDLE: if any req is high, grant one port, latch its address into flash_mem_address and go to ISSUE; otherwise stay.
REQ-021 Arbitration: a single requester wins outright; if both are high, grant the port not granted last (round-robin pointer last_grant, updated at grant).
REQ-022 ISSUE: flash_mem_read=1 with the latched address; stay while waitrequest=1.
REQ-023 ISSUE, acceptance edge (waitrequest=0): go to WAIT_DATA; flash_mem_read=0 and granted r*_ack=1 for exactly the next cycle.
REQ-024 readdatavalid is ignored in IDLE, ISSUE and RESP; data is captured only in WAIT_DATA.
REQ-025 WAIT_DATA: an 8-bit counter clears on entry and increments each cycle readdatavalid=0.
REQ-026 WAIT_DATA with readdatavalid=1: capture readdata into the granted r*_data, err=0, go to RESP.
REQ-027 WAIT_DATA, counter == TIMEOUT with no readdatavalid: r*_data=32'h0, err=1, go to RESP; readdatavalid in that same cycle takes priority (normal completion).
REQ-028 RESP: granted r*_valid=1 for exactly one cycle, then IDLE; the new arbitration happens in IDLE on the following cycle.
REQ-029 Minimum service time: req seen in IDLE at cycle N -> read at N+1 -> ack at N+2 -> earliest valid at N+3 (readdatavalid at N+2) -> IDLE at N+4.
REQ-030 The ungranted port's ack, valid and err stay 0 throughout; its req may remain high and is served next.
REQ-031 A req dropped before its ack is a protocol violation; the latched address is used regardless and the response is still delivered.

Reset
REQ-032 While reset_reset_n=1, immediately: state=IDLE, last_grant=1 (port 0 wins the first tie), counter=0, flash_mem_read=0, flash_mem_address=0, all ack/valid/err=0, r0_data=r1_data=32'h0.
REQ-033 Reset mid-transaction abandons it with no valid pulse; a late readdatavalid after reset is ignored (REQ-024).

Verification
REQ-034 Single read: r0_req, addr 23'h000010; waitrequest low; readdatavalid with 32'hDEADBEEF two cycles after ack -> one r0_ack, then one r0_valid, r0_data=32'hDEADBEEF, r0_err=0; port 1 outputs stay 0.
REQ-035 Contention: both req high from reset release, addr0=23'h5, addr1=23'h9, each held until its ack -> flash sees address 5 then 9; ack/valid order r0 then r1; no overlap of flash_mem_read with an outstanding transaction.
REQ-036 Stall: waitrequest high for 5 cycles during ISSUE -> flash_mem_read and address held for 6 cycles, r*_ack only after waitrequest falls.
REQ-037 Timeout: TIMEOUT=8'd10 and readdatavalid never asserted -> valid with err=1 and data=32'h0 exactly 11 WAIT_DATA cycles after entry; the next request is served normally.
REQ-038 Reset in WAIT_DATA, readdatavalid pulsed 2 cycles after release -> no valid pulse, state IDLE, all outputs at reset values.
REQ-039 Stray readdatavalid while IDLE with data 32'h12345678 -> no valid pulse, r*_data unchanged.
